// File: rtl/spi_ctrl.sv
// spi_ctrl: byte sequencer driving the spi_shift serializer (SPI mode 0).
// CS stays low across a multi-byte transaction until a last byte completes.
module spi_ctrl #(
    parameter int DW      = 8,
    parameter int HALF    = 2,
    parameter int CS_HOLD = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    input  logic          i_dc,
    input  logic          i_last,
    output logic          o_ready,
    output logic          o_load,
    output logic          o_shift_en,
    output logic [DW-1:0] o_data,
    output logic          o_dc,
    output logic          o_cs,
    output logic          o_sclk,
    output logic          o_busy,
    output logic          o_done
);
    localparam int HP   = (HALF < 1) ? 1 : HALF;
    localparam int CMAX = (HP > CS_HOLD) ? HP : CS_HOLD;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(DW + 1);
    localparam logic [CW-1:0] PH_END = CW'(HP - 1);
    localparam logic [CW-1:0] HD_END = CW'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);
    localparam logic [BW-1:0] BITS   = BW'(DW);

    typedef enum logic [2:0] {IDLE, LOAD, PRE, HIGH, LOW, HOLD, REL} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [BW-1:0] bit_q;
    logic [BW-1:0] bit_d;
    logic          last_q;
    logic          ph_end;
    logic          byte_end;

    assign bit_d    = bit_q + 1'b1;
    assign ph_end   = (cnt_q == PH_END);
    assign byte_end = (state_q == LOW) && ph_end && (bit_q == BITS);
    assign o_busy   = (state_q != IDLE);
    assign o_ready  = (state_q == IDLE) || (byte_end && !last_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            last_q     <= 1'b0;
            o_load     <= 1'b0;
            o_shift_en <= 1'b0;
            o_data     <= '1;
            o_dc       <= 1'b1;
            o_cs       <= 1'b1;
            o_sclk     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_load     <= 1'b0;
            o_shift_en <= 1'b0;
            o_done     <= 1'b0;
            // Accept covers both IDLE and the back-to-back slot at the end of LOW.
            if (i_valid && o_ready) begin
                state_q <= LOAD;
                last_q  <= i_last;
                o_load  <= 1'b1;
                o_data  <= i_data;
                o_dc    <= i_dc;
                o_cs    <= 1'b0;
                o_sclk  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: ;
                    LOAD: begin
                        state_q    <= PRE;
                        cnt_q      <= '0;
                        o_shift_en <= 1'b1;
                    end
                    PRE: begin
                        if (ph_end) begin
                            state_q <= HIGH;
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            o_sclk  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    HIGH: begin
                        if (ph_end) begin
                            state_q    <= LOW;
                            cnt_q      <= '0;
                            bit_q      <= bit_d;
                            o_sclk     <= 1'b0;
                            o_shift_en <= (bit_d < BITS);
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    LOW: begin
                        if (!ph_end) begin
                            cnt_q <= cnt_q + 1'b1;
                        end else if (bit_q != BITS) begin
                            state_q <= HIGH;
                            cnt_q   <= '0;
                            o_sclk  <= 1'b1;
                        end else if (!last_q) begin
                            state_q <= IDLE;
                        end else if (CS_HOLD == 0) begin
                            state_q <= REL;
                            o_load  <= 1'b1;
                            o_data  <= '1;
                            o_cs    <= 1'b1;
                            o_done  <= 1'b1;
                        end else begin
                            state_q <= HOLD;
                            cnt_q   <= '0;
                        end
                    end
                    HOLD: begin
                        if (cnt_q == HD_END) begin
                            state_q <= REL;
                            o_load  <= 1'b1;
                            o_data  <= '1;
                            o_cs    <= 1'b1;
                            o_done  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    REL: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_ctrl.sv
// tb_spi_ctrl: vector table, directed corner cases and random traffic,
// checked by a MOSI-level monitor against a queue of accepted bytes.
module tb_spi_ctrl;
    localparam int H        = 2;
    localparam int CH       = 2;
    localparam int BYTE_LEN = 1 + H + 2 * 8 * H;

    typedef struct {
        logic [7:0] d;
        logic       dc;
        logic       last;
    } byte_t;

    typedef struct {
        logic [7:0] d;
        logic       dc;
        logic       last;
        int         exp_len;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_valid = 1'b0;
    logic [7:0] a_idata = 8'h00;
    logic       a_idc = 1'b0;
    logic       a_ilast = 1'b0;
    logic       a_ready, a_load, a_shift_en, a_dc, a_cs, a_sclk, a_busy, a_done;
    logic [7:0] a_data;

    logic       b_valid = 1'b0;
    logic [7:0] b_idata = 8'h00;
    logic       b_idc = 1'b0;
    logic       b_ilast = 1'b0;
    logic       b_ready, b_load, b_shift_en, b_dc, b_cs, b_sclk, b_busy, b_done;
    logic [7:0] b_data;

    spi_ctrl #(.DW(8), .HALF(H), .CS_HOLD(CH)) u_a (
        .clk(clk), .rst(rst_n),
        .i_valid(a_valid), .i_data(a_idata), .i_dc(a_idc), .i_last(a_ilast),
        .o_ready(a_ready), .o_load(a_load), .o_shift_en(a_shift_en),
        .o_data(a_data), .o_dc(a_dc), .o_cs(a_cs), .o_sclk(a_sclk),
        .o_busy(a_busy), .o_done(a_done)
    );

    spi_ctrl #(.DW(8), .HALF(1), .CS_HOLD(0)) u_b (
        .clk(clk), .rst(rst_n),
        .i_valid(b_valid), .i_data(b_idata), .i_dc(b_idc), .i_last(b_ilast),
        .o_ready(b_ready), .o_load(b_load), .o_shift_en(b_shift_en),
        .o_data(b_data), .o_dc(b_dc), .o_cs(b_cs), .o_sclk(b_sclk),
        .o_busy(b_busy), .o_done(b_done)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Reference: shifter model plus queue of bytes the driver saw accepted.
    byte_t      expq[$];
    logic [7:0] sh = 8'hFF;
    logic [7:0] rx = 8'h00;
    logic       mosi = 1'b1;
    logic       prev_sclk = 1'b0, prev_cs = 1'b1, prev_done = 1'b0;
    logic       dc_bad = 1'b0, cs_bad = 1'b0;
    int         cyc = 0, nbits = 0, last_load = 0, first_load = 0;
    int         trans_len = 0, done_cnt = 0, idle_sclk_bad = 0;

    always @(negedge clk) begin
        byte_t e;
        cyc++;
        if (!rst_n) begin
            expq.delete();
            nbits = 0; sh = 8'hFF; mosi = 1'b1;
            prev_sclk = 1'b0; prev_cs = 1'b1; prev_done = 1'b0;
        end else begin
            if (a_sclk && !prev_sclk) begin
                if (nbits == 0) begin dc_bad = 1'b0; cs_bad = 1'b0; end
                rx = {rx[6:0], mosi};
                nbits++;
                if (a_cs) cs_bad = 1'b1;
                if (expq.size() > 0 && a_dc !== expq[0].dc) dc_bad = 1'b1;
                if (nbits == 8) begin
                    nbits = 0;
                    if (expq.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL byte_unexpected: got %0h want none", rx);
                    end else begin
                        e = expq.pop_front();
                        chk("mosi_byte", rx, e.d);
                        chk("byte_dc_bad", dc_bad, 1'b0);
                        chk("byte_cs_bad", cs_bad, 1'b0);
                    end
                end
            end
            if (!a_busy && a_sclk) idle_sclk_bad++;
            if (!prev_cs && a_cs) chk("cs_rise_at_rel", a_done, 1'b1);
            if (a_load && !a_cs) begin
                last_load = cyc;
                if (prev_cs) first_load = cyc;
            end
            if (a_done) begin
                chk("last_byte_len", cyc - last_load + 1, BYTE_LEN + CH + 1);
                chk("done_single", prev_done, 1'b0);
                chk("rel_data", a_data, 8'hFF);
                trans_len = cyc - first_load + 1;
                done_cnt++;
            end
            if (a_load) sh = a_data;
            else if (a_shift_en) begin mosi = sh[7]; sh = {sh[6:0], 1'b1}; end
            prev_sclk = a_sclk; prev_cs = a_cs; prev_done = a_done;
        end
    end

    task automatic send(input logic [7:0] d, input logic dc, input logic last);
        bit acc;
        acc = 1'b0;
        a_valid = 1'b1; a_idata = d; a_idc = dc; a_ilast = last;
        for (int k = 0; k < 200; k++) begin
            if (a_ready) begin
                expq.push_back('{d, dc, last});
                acc = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (!acc) begin
            a_valid = 1'b0;
            chk("accept_timeout", acc, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string nm);
        int start;
        bit seen;
        start = done_cnt; seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done_cnt != start) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk(nm, seen, 1'b1);
    endtask

    task automatic run_b;
        logic [7:0] bsh, brx;
        logic       bmosi, ps, cs_lastlow, cs_done;
        int         rises, last_rise, gap_bad, busy_n, done_n, done_at, dc_err;
        bsh = 8'hFF; brx = 8'h00; bmosi = 1'b1; ps = 1'b0;
        cs_lastlow = 1'b1; cs_done = 1'b0;
        rises = 0; last_rise = -10; gap_bad = 0; busy_n = 0;
        done_n = 0; done_at = -1; dc_err = 0;
        chk("b_ready_idle", b_ready, 1'b1);
        b_valid = 1'b1; b_idata = 8'hA5; b_idc = 1'b1; b_ilast = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (b_sclk && !ps) begin
                brx = {brx[6:0], bmosi};
                if (rises > 0 && k - last_rise != 2) gap_bad++;
                if (b_dc !== 1'b1) dc_err++;
                last_rise = k;
                rises++;
            end
            if (rises == 8 && k == last_rise + 1) cs_lastlow = b_cs;
            if (b_busy) busy_n++;
            if (b_done) begin done_n++; done_at = k; cs_done = b_cs; end
            if (b_load) bsh = b_data;
            else if (b_shift_en) begin bmosi = bsh[7]; bsh = {bsh[6:0], 1'b1}; end
            ps = b_sclk;
            @(negedge clk);
        end
        chk("b_busy_cycles", busy_n, 19);
        chk("b_rises", rises, 8);
        chk("b_sclk_period", gap_bad, 0);
        chk("b_byte", brx, 8'hA5);
        chk("b_dc", dc_err, 0);
        chk("b_done_count", done_n, 1);
        chk("b_rel_after_low", done_at, last_rise + 2);
        chk("b_cs_last_low", cs_lastlow, 1'b0);
        chk("b_cs_rel", cs_done, 1'b1);
    endtask

    vec_t tbl[7];

    initial begin
        int k_acc, bad, waited;
        tbl[0] = '{8'h2A, 1'b0, 1'b1, 38};
        tbl[1] = '{8'hFF, 1'b1, 1'b1, 38};
        tbl[2] = '{8'h00, 1'b0, 1'b1, 38};
        tbl[3] = '{8'h2C, 1'b0, 1'b0, 0};
        tbl[4] = '{8'hF8, 1'b1, 1'b0, 0};
        tbl[5] = '{8'h00, 1'b1, 1'b1, 108};
        tbl[6] = '{8'h81, 1'b1, 1'b1, 38};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", a_ready, 1'b1);
        chk("rst_cs", a_cs, 1'b1);
        chk("rst_sclk", a_sclk, 1'b0);
        chk("rst_data", a_data, 8'hFF);
        chk("rst_dc", a_dc, 1'b1);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_load_done", {a_load, a_shift_en, a_done}, 3'b000);

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].d, tbl[i].dc, tbl[i].last);
            if (tbl[i].last) begin
                a_valid = 1'b0;
                wait_done("tbl_done");
                chk("tbl_trans_len", trans_len, tbl[i].exp_len);
                idle(2);
            end
        end

        // Hold-off: data churns while busy, only the o_ready cycle counts.
        send(8'h3C, 1'b0, 1'b0);
        k_acc = -1;
        a_valid = 1'b1; a_idc = 1'b1; a_ilast = 1'b1;
        for (int k = 0; k < 200; k++) begin
            a_idata = 8'($urandom);
            if (a_ready) begin
                expq.push_back('{a_idata, 1'b1, 1'b1});
                k_acc = k;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        a_valid = 1'b0;
        chk("holdoff_wait", k_acc, BYTE_LEN - 1);
        wait_done("holdoff_done");
        idle(2);

        // Stalled stream: CS stays low, SCLK idle, ready up.
        send(8'h11, 1'b0, 1'b0);
        a_valid = 1'b0;
        waited = 0;
        while (a_busy && waited < 100) begin @(negedge clk); waited++; end
        chk("stall_busy_drop", a_busy, 1'b0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (!a_ready || a_cs || a_sclk) bad++;
            @(negedge clk);
        end
        chk("stall_gap", bad, 0);
        send(8'h22, 1'b1, 1'b1);
        a_valid = 1'b0;
        wait_done("stall_done");
        idle(2);

        run_b();

        // Mid-byte async reset during HIGH.
        send(8'h5A, 1'b1, 1'b1);
        a_valid = 1'b0;
        waited = 0;
        while (!a_sclk && waited < 30) begin @(negedge clk); waited++; end
        chk("mid_reach_high", a_sclk, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sclk", a_sclk, 1'b0);
        chk("mid_rst_cs", a_cs, 1'b1);
        chk("mid_rst_data", a_data, 8'hFF);
        chk("mid_rst_busy", a_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", a_ready, 1'b1);

        for (int i = 0; i < 40; i++) begin
            int gap;
            logic lst;
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(gap);
            lst = (i == 39) || ($urandom_range(0, 2) == 0);
            send(8'($urandom), 1'($urandom), lst);
        end
        a_valid = 1'b0;
        wait_done("rand_done");
        waited = 0;
        while (a_busy && waited < 100) begin @(negedge clk); waited++; end
        chk("rand_idle", a_busy, 1'b0);
        chk("queue_drained", expq.size(), 0);
        chk("idle_sclk", idle_sclk_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_ctrl.md
Name: spi_ctrl

Overview:
- Byte-level sequencer for the `spi_shift` serializer in the ILI9341 SPI path.
- Accepts command/data bytes over a valid/ready handshake and generates SCLK (SPI mode 0).
- Drives the shifter's load, shift-enable, data, D/C and CS inputs.
- Holds CS low across a multi-byte transaction and releases it after the byte flagged last.

Parameters:
DW, 8, byte width; must match the shifter.
HALF, 2, SCLK half-period in clk cycles (minimum 1; 0 is treated as 1).
CS_HOLD, 2, clk cycles CS stays low after the final falling SCLK edge of a last byte.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
i_valid  input  1  byte available
i_data  input  DW  byte to send, MSB first
i_dc  input  1  0 = command, 1 = data
i_last  input  1  release CS after this byte
o_ready  output  1  byte accepted when i_valid && o_ready
o_load  output  1  shifter load strobe
o_shift_en  output  1  shifter shift strobe
o_data  output  DW  shifter parallel data
o_dc  output  1  shifter D/C input
o_cs  output  1  shifter CS input (active low)
o_sclk  output  1  SPI clock to panel
o_busy  output  1  high whenever state != IDLE
o_done  output  1  one-cycle pulse when a last byte's CS release load issues

Behaviour:
- Reset (async, rst=0), any state: state=IDLE, o_sclk=0, o_load=0, o_shift_en=0, o_data=all ones, o_dc=1, o_cs=1, o_busy=0, o_done=0, o_ready=1 after release.
  - A mid-byte reset aborts the byte. No partial CS release is generated; the shifter is reset by the same rst.
- All outputs are registered except o_ready and o_busy, which decode state.
- States: IDLE, LOAD, PRE, HIGH, LOW, HOLD, REL.
- IDLE:
  - o_ready=1.
  - On accept: latch i_data, i_dc, i_last; go to LOAD.
  - CS keeps its last driven value, so it stays low between non-last bytes.
- LOAD (1 cycle):
  - o_load=1, o_data=latched byte, o_dc=latched dc, o_cs=0.
  - Go to PRE.
- PRE (HALF cycles):
  - o_shift_en=1 on the first cycle only; this presents bit DW-1 on MOSI. o_sclk=0.
  - Go to HIGH; bit counter = 0.
- HIGH (HALF cycles):
  - o_sclk=1; the panel samples on the rising edge.
  - Go to LOW.
- LOW (HALF cycles):
  - o_sclk=0.
  - Increment the bit counter on entry.
  - o_shift_en=1 on the first cycle only if the counter is < DW after increment; the DW-th falling edge gives no shift.
  - If counter < DW, go to HIGH at the end of the phase.
  - If counter = DW and the byte is not last: the last cycle asserts o_ready.
    - Accept -> LOAD (back-to-back, CS stays low).
    - No accept -> IDLE.
  - If counter = DW and the byte is last: go to HOLD.
- HOLD (CS_HOLD cycles, skipped if 0):
  - o_cs remains 0.
  - Go to REL.
- REL (1 cycle):
  - o_load=1, o_data=all ones, o_cs=1, o_dc unchanged, o_done=1.
  - Go to IDLE.
- Byte timing: exactly DW rising SCLK edges per byte. Each shift pulse is HALF cycles before the next rising edge.
- Per-byte length:
  - 1 + HALF + 2*DW*HALF clk cycles.
  - With DW=8 and HALF=2, that is 35 cycles from LOAD entry to the end of the last LOW.
- Back-to-back bytes: no idle cycle between the last LOW cycle and the next LOAD.
- i_valid asserted while o_ready=0 is held off; inputs are not sampled.
- o_sclk never toggles outside HIGH/LOW. o_sclk idles low.

Test Plan:
- Reset: apply rst=0 mid-byte (during HIGH) -> o_sclk=0, o_cs=1, o_data=8'hFF, o_busy=0 the same cycle; o_ready=1 after release.
- Single command: send 0x2A, dc=0, last=1, HALF=2.
  - Expect 8 rising SCLK edges with MOSI = 0,0,1,0,1,0,1,0 at each rise and o_dc=0.
  - Expect CS low from LOAD+1 until CS_HOLD cycles after the 8th fall.
  - Expect o_done pulsed once; total 35 + 2 + 1 cycles.
- Back-to-back bytes: send 0x2C(dc=0, last=0), 0xF8(dc=1, last=0), 0x00(dc=1, last=1) with i_valid held.
  - Expect CS low continuously for all 24 bits and no gap cycle between bytes.
  - Expect o_dc to switch at the second LOAD.
- Stalled stream: byte 0x11 last=0, then i_valid low for 20 cycles, then 0x22 last=1.
  - Expect o_ready=1 and CS low with o_sclk=0 during the gap, then correct transmission of 0x22.
- Handshake hold-off: i_valid=1 with a changing i_data during a transfer -> the in-flight byte is unaffected; the new byte is accepted only on the o_ready cycle.
- HALF=1, CS_HOLD=0: send one byte -> SCLK period is 2 clk cycles, HOLD is skipped, and REL follows the last LOW directly.
